// File: rtl/mpt_leaf_check_stage.sv
// rtl/mpt_leaf_check_stage.sv - terminal MPT walker stage: leaf permission check, 2-entry skid output, deny counter
// Bus layout: [0] valid, [2:1] walking, [4:3] access, [6:5] fault, [7] allow, [15:8] paddr[15:8], [W-1:16] mpte.
module mpt_leaf_check_stage #(
  parameter int PIPELINE_SLAVE_DATA_WIDTH  = 32,
  parameter int PIPELINE_MASTER_DATA_WIDTH = 32,
  parameter int FAULT_COUNT_WIDTH          = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  stage_slave_valid,
  output logic                                  stage_slave_ready,
  input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  stage_slave_data,
  output logic                                  stage_master_valid,
  input  logic                                  stage_master_ready,
  output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] stage_master_data,
  output logic                                  permission_fault_o,
  output logic [FAULT_COUNT_WIDTH-1:0]          fault_count_o,
  input  logic                                  clear_count_i
);

  localparam int SW = PIPELINE_SLAVE_DATA_WIDTH;
  localparam int MW = PIPELINE_MASTER_DATA_WIDTH;
  localparam int CW = FAULT_COUNT_WIDTH;

  localparam logic [1:0] MPT_WALKING_DO = 2'd2;
  localparam logic [1:0] ACCESS_R       = 2'd0;
  localparam logic [1:0] ACCESS_W       = 2'd1;
  localparam logic [1:0] ACCESS_X       = 2'd2;
  localparam logic [1:0] PERM_DENIED    = 2'd2;
  localparam logic [1:0] PERM_RESERVED  = 2'd3;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;

  logic [1:0]    walking;
  logic [1:0]    access;
  logic [1:0]    fault_in;
  logic [3:0]    page_idx;
  logic [63:0]   mpte_ext;
  logic [3:0]    perm;
  logic          access_ok;
  logic          allow_d;
  logic [1:0]    fault_d;
  logic [SW-1:0] dec_data;

  assign walking  = stage_slave_data[2:1];
  assign access   = stage_slave_data[4:3];
  assign fault_in = stage_slave_data[6:5];
  assign page_idx = stage_slave_data[15:12];
  // Nibbles past the end of the mpte field read as zero, i.e. no permission.
  assign mpte_ext = 64'(stage_slave_data[SW-1:16]);
  assign perm     = mpte_ext[{page_idx, 2'b00} +: 4];

  always_comb begin
    access_ok = 1'b0;
    unique case (access)
      ACCESS_R: access_ok = perm[0];
      ACCESS_W: access_ok = perm[1] & perm[0];
      ACCESS_X: access_ok = perm[2];
      default:  access_ok = 1'b0;
    endcase
  end

  always_comb begin
    allow_d = 1'b1;
    fault_d = fault_in;
    if (walking == MPT_WALKING_DO) begin
      if (fault_in != 2'd0) begin
        allow_d = 1'b0;
      end else if (perm[3]) begin
        allow_d = 1'b0;
        fault_d = PERM_RESERVED;
      end else if (!access_ok) begin
        allow_d = 1'b0;
        fault_d = PERM_DENIED;
      end
    end
    dec_data      = stage_slave_data;
    dec_data[7]   = allow_d;
    dec_data[6:5] = fault_d;
  end

  skid_state_e   state_q;
  logic [SW-1:0] head_q;
  logic [SW-1:0] tail_q;
  logic          master_valid_q;
  logic          slave_ready_q;
  logic          accept;
  logic          drain;

  assign accept = stage_slave_valid && slave_ready_q;
  assign drain  = master_valid_q && stage_master_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= EMPTY;
      head_q         <= '0;
      tail_q         <= '0;
      master_valid_q <= 1'b0;
      slave_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_q         <= dec_data;
            state_q        <= ONE;
            master_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head_q <= dec_data;
          end else if (accept) begin
            tail_q        <= dec_data;
            state_q       <= TWO;
            slave_ready_q <= 1'b0;
          end else if (drain) begin
            state_q        <= EMPTY;
            master_valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (drain) begin
            head_q        <= tail_q;
            state_q       <= ONE;
            slave_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q        <= EMPTY;
          master_valid_q <= 1'b0;
          slave_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign stage_slave_ready  = slave_ready_q;
  assign stage_master_valid = master_valid_q;
  assign stage_master_data  = MW'(head_q);

  logic          deny_drain;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          fault_pulse_q;

  assign deny_drain = drain && !head_q[7];

  always_comb begin
    count_d = count_q;
    if (clear_count_i) begin
      count_d = '0;
    end else if (deny_drain && (count_q != {CW{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q       <= '0;
      fault_pulse_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      fault_pulse_q <= deny_drain;
    end
  end

  assign permission_fault_o = fault_pulse_q;
  assign fault_count_o      = count_q;

endmodule

// File: tb/tb_mpt_leaf_check_stage.sv
// tb/tb_mpt_leaf_check_stage.sv - directed vector bench for mpt_leaf_check_stage
module tb_mpt_leaf_check_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic [31:0] s_data;
  logic        m_ready;
  logic        clear;
  logic        s_ready, m_valid, pfault;
  logic [31:0] m_data;
  logic [15:0] count;
  logic        s_ready2, m_valid2, pfault2;
  logic [31:0] m_data2;
  logic [1:0]  count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mpt_leaf_check_stage dut (
    .clk_i(clk), .rst_ni(rst_n),
    .stage_slave_valid(s_valid), .stage_slave_ready(s_ready), .stage_slave_data(s_data),
    .stage_master_valid(m_valid), .stage_master_ready(m_ready), .stage_master_data(m_data),
    .permission_fault_o(pfault), .fault_count_o(count), .clear_count_i(clear)
  );

  mpt_leaf_check_stage #(.FAULT_COUNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n),
    .stage_slave_valid(s_valid), .stage_slave_ready(s_ready2), .stage_slave_data(s_data),
    .stage_master_valid(m_valid2), .stage_master_ready(m_ready), .stage_master_data(m_data2),
    .permission_fault_o(pfault2), .fault_count_o(count2), .clear_count_i(clear)
  );

  typedef struct {
    logic [31:0] din;
    logic        allow;
    logic [1:0]  fault;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [31:0] mk(input logic [1:0] walking, input logic [1:0] access,
                                     input logic [1:0] fault, input logic [3:0] idx,
                                     input logic [15:0] mpte, input logic allow_in);
    return {mpte, idx, 4'h5, allow_in, fault, access, walking, 1'b1};
  endfunction

  function automatic logic [31:0] expect_of(input vec_t v);
    logic [31:0] e;
    e = v.din;
    e[7] = v.allow;
    e[6:5] = v.fault;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Sends one transaction with downstream ready and lets it drain.
  task automatic push(input logic [31:0] din);
    s_valid = 1'b1;
    s_data  = din;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int exp_count;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; clear = 1'b0;

    // walking: 0 disabled, 1 bypass, 2 DO; access: 0 R, 1 W, 2 X
    vecs[0]  = '{mk(2'd2, 2'd0, 2'd0, 4'd3, 16'h1000, 1'b0), 1'b1, 2'd0};
    vecs[1]  = '{mk(2'd2, 2'd1, 2'd0, 4'd1, 16'h0020, 1'b0), 1'b0, 2'd2};
    vecs[2]  = '{mk(2'd2, 2'd1, 2'd0, 4'd1, 16'h0030, 1'b0), 1'b1, 2'd0};
    vecs[3]  = '{mk(2'd2, 2'd2, 2'd1, 4'd3, 16'h7000, 1'b0), 1'b0, 2'd1};
    vecs[4]  = '{mk(2'd1, 2'd0, 2'd0, 4'd3, 16'h0000, 1'b0), 1'b1, 2'd0};
    vecs[5]  = '{mk(2'd1, 2'd1, 2'd1, 4'd0, 16'h0000, 1'b0), 1'b1, 2'd1};
    vecs[6]  = '{mk(2'd2, 2'd0, 2'd0, 4'd3, 16'h8000, 1'b0), 1'b0, 2'd3};
    vecs[7]  = '{mk(2'd2, 2'd0, 2'd0, 4'd0, 16'h000F, 1'b1), 1'b0, 2'd3};
    vecs[8]  = '{mk(2'd2, 2'd2, 2'd0, 4'd2, 16'h0400, 1'b0), 1'b1, 2'd0};
    vecs[9]  = '{mk(2'd2, 2'd2, 2'd0, 4'd2, 16'h0300, 1'b0), 1'b0, 2'd2};
    vecs[10] = '{mk(2'd0, 2'd2, 2'd0, 4'd2, 16'h0000, 1'b0), 1'b1, 2'd0};
    vecs[11] = '{mk(2'd2, 2'd1, 2'd0, 4'd0, 16'h0001, 1'b0), 1'b0, 2'd2};

    @(negedge clk);
    chk("reset_master_valid", 32'(m_valid), 32'd0);
    chk("reset_master_data", m_data, 32'd0);
    chk("reset_slave_ready", 32'(s_ready), 32'd1);
    chk("reset_fault_pulse", 32'(pfault), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    exp_count = 0;
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1;
      s_data  = vecs[i].din;
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(m_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), m_data, expect_of(vecs[i]));
      @(posedge clk);
      if (!vecs[i].allow) exp_count++;
      @(negedge clk);
      chk($sformatf("vec%0d_drained", i), 32'(m_valid), 32'd0);
      chk($sformatf("vec%0d_fault_pulse", i), 32'(pfault), 32'(!vecs[i].allow));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(exp_count));
      @(posedge clk); #1;
    end
    chk("fault_pulse_one_cycle", 32'(pfault), 32'd0);

    // Back-pressure: A and B fill the skid, C stalls until release.
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = vecs[0].din;
    @(posedge clk); #1;
    s_data = vecs[2].din;
    @(posedge clk); #1;
    s_data = vecs[8].din;
    @(negedge clk);
    chk("stall_slave_ready", 32'(s_ready), 32'd0);
    chk("stall_head_a", m_data, expect_of(vecs[0]));
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_hold_valid", 32'(m_valid), 32'd1);
    chk("stall_hold_a", m_data, expect_of(vecs[0]));
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("release_a", m_data, expect_of(vecs[0]));
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_b_valid", 32'(m_valid), 32'd1);
    chk("release_b", m_data, expect_of(vecs[2]));
    chk("release_ready_back", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("release_c_valid", 32'(m_valid), 32'd1);
    chk("release_c", m_data, expect_of(vecs[8]));
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_empty", 32'(m_valid), 32'd0);
    chk("release_count_unchanged", 32'(count), 32'(exp_count));
    @(posedge clk); #1;

    // Saturation on the 2-bit instance: clear, reach max-1, then 3 more denies.
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_count", 32'(count), 32'd0);
    push(vecs[1].din);
    push(vecs[9].din);
    chk("sat_near_max", 32'(count2), 32'd2);
    for (int k = 0; k < 3; k++) push(vecs[11].din);
    chk("sat_at_max", 32'(count2), 32'd3);
    chk("wide_count_five", 32'(count), 32'd5);

    // Clear in the same cycle a deny drains.
    s_valid = 1'b1; s_data = vecs[6].din;
    @(posedge clk); #1;
    s_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clear_wins_count", 32'(count), 32'd0);
    chk("clear_wins_count_sat", 32'(count2), 32'd0);
    chk("clear_deny_pulse", 32'(pfault), 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset while both entries are full.
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = vecs[1].din;
    @(posedge clk); #1;
    s_data = vecs[2].din;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("two_full_ready", 32'(s_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(m_valid), 32'd0);
    chk("async_rst_ready", 32'(s_ready), 32'd1);
    chk("async_rst_data", m_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("no_stale_%0d", k), {30'd0, m_valid, pfault}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
